mdu_issue_ctrl: RTL and testbench
=================================

Name: mdu_issue_ctrl

Overview:
- Initiator-side controller for the multiply/divide unit's start/busy protocol. It sits in the E stage beside the multiply/divide unit.
- Decides when an MDU-using instruction in D must stall, based on the MDU op issued from E and the unit's start/busy handshake.
- Tracks every issued op with a shadow latency counter, flags any handshake violation by the unit, and counts MDU stall cycles for performance analysis.
- Honours exception request Req as a global freeze of the MDU side.

Parameters:
- MULT_CYCLES, 5, busy-high cycles expected for mult/multu.
- DIV_CYCLES, 10, busy-high cycles expected for div/divu.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Req  input  1  exception/interrupt request. When high, the MDU ignores the E-stage op and holds its state.
- MDUtype_D  input  4  MDU op code of the D-stage instruction (0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo).
- MDUtype_E  input  4  MDU op code of the E-stage instruction, same encoding.
- start  input  1  from the MDU; high when E holds mult/multu/div/divu and Req=0.
- busy  input  1  from the MDU.
- stall_D  output  1  freeze F/D and bubble E.
- proto_err  output  1  sticky handshake-violation flag.
- err_code  output  2  first violation: 0 none, 1 busy late, 2 busy early-drop, 3 busy overrun.
- stall_cnt  output  CNT_W  number of cycles stall_D was high.
- shadow_busy  output  1  controller's own prediction of MDU busy.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state IDLE; shadow counter 0.
- use_D = MDUtype_D in 1..8. Values 9..15 are treated as none.
- stall_D, combinational: use_D & (start | busy | shadow_busy).
- FSM states:
  - IDLE to ARMED on start=1 (implies Req=0). On that edge, load exp = MULT_CYCLES for op 1/2, DIV_CYCLES for op 3/4.
  - ARMED: the cycle after start, busy must be 1. If so, go to RUN, exp <= exp-1, shadow_busy=1. If not, proto_err with code 1, then IDLE.
  - RUN, each cycle with Req=0:
    - busy=0 while exp>0: proto_err with code 2, then IDLE.
    - exp==0 and busy=0: IDLE, shadow_busy=0. This is a clean completion.
    - exp==0 and busy=1: proto_err with code 3, remain in RUN until busy=0, then IDLE.
    - Otherwise exp <= exp-1.
  - Example (mult): start in cycle t; busy is high for cycles t+1..t+5; busy is 0 in cycle t+6.
- Req=1 in any state: FSM, exp and shadow_busy hold. The MDU freezes identically, so no error checks run that cycle. stall_cnt still counts.
- start while state is not IDLE: proto_err with code 3. The new op is ignored for tracking.
- proto_err is sticky. err_code records only the first violation. Both clear on reset only.
- stall_cnt increments by 1 on each edge where stall_D=1, wraps at 2^CNT_W-1 to 0, and never saturates.
- Reset mid-op: returns to IDLE immediately on that edge regardless of busy.
- mthi/mtlo/mfhi/mflo in E never assert start and never change state.

Decomposition:
- Shared package holds:
  - MDU op code constants MDU_NONE..MDU_MTLO (values 0..8);
  - err_code constants ERR_NONE, ERR_LATE, ERR_DROP, ERR_OVERRUN;
  - FSM state encoding IDLE/ARMED/RUN.
- One natural sub-module: mdu_lat_counter, which does load/decrement/hold on Req and provides a zero flag, instantiated once.

Test Plan:
- mult in E (start at t); model busy high t+1..t+5; mfhi in D from t → stall_D=1 for t..t+5, 0 at t+6; stall_cnt=6; proto_err=0.
- div with Req pulsed high at cycle t+3 for 2 cycles; MDU busy extended to t+12 → no error; shadow_busy falls together with busy; stall_D tracks it.
- Faulty model drops busy after 3 cycles of divu → proto_err=1, err_code=2, held until reset; a later late-busy fault leaves err_code=2.
- Faulty model keeps busy 7 cycles after multu → err_code=3; FSM returns to IDLE when busy falls.
- D holds addu (MDUtype_D=0) during busy → stall_D=0 throughout; stall_cnt unchanged.
- reset asserted during RUN of div → next cycle: state IDLE, all outputs 0, stall_cnt=0.

Source files
------------

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared op codes, error codes and FSM encoding for the MDU issue controller.
// Latency: n/a (types and pure helpers only); backpressure: n/a.
package mdu_issue_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LATE    = 2'd1,
        ERR_DROP    = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Codes 9..15 are unused encodings and count as no MDU use.
    function automatic logic is_mdu_use(input logic [3:0] op);
        return (op >= 4'(MDU_MULT)) && (op <= 4'(MDU_MTLO));
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op == 4'(MDU_MULT)) || (op == 4'(MDU_MULTU));
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == 4'(MDU_DIV)) || (op == 4'(MDU_DIVU));
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_lat_counter.sv
// Shadow latency counter: load, decrement toward zero, hold while frozen.
// Latency: value updates on the next edge; backpressure: hold freezes all updates.
module mdu_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!hold) begin
            if (load) begin
                cnt <= load_val;
            end else if (dec && (cnt != '0)) begin
                cnt <= cnt - W'(1);
            end
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// D-stage stall control and start/busy protocol monitor for the multiply/divide unit.
// Latency: stall_D is combinational, state/errors register on the edge; backpressure: Req freezes tracking.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req,
    input  logic [3:0]       MDUtype_D,
    input  logic [3:0]       MDUtype_E,
    input  logic             start,
    input  logic             busy,
    output logic             stall_D,
    output logic             proto_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             shadow_busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int EXP_W      = $clog2(MAX_CYCLES + 1);

    state_e           state;
    state_e           state_nxt;
    err_e             err_q;
    err_e             err_val;
    logic             err_vld;
    logic             cnt_load;
    logic             cnt_dec;
    logic             exp_zero;
    logic [EXP_W-1:0] load_val;
    logic             use_D;
    logic             track_start;

    assign use_D       = is_mdu_use(MDUtype_D);
    // Only real mult/div ops are tracked; a start beside mfhi/mflo/mthi/mtlo is ignored.
    assign track_start = start && (is_mul(MDUtype_E) || is_div(MDUtype_E));
    assign shadow_busy = (state == RUN) && !exp_zero;
    assign stall_D     = use_D && (start || busy || shadow_busy);
    assign err_code    = err_q;

    always_comb begin
        load_val = EXP_W'(DIV_CYCLES);
        if (is_mul(MDUtype_E)) begin
            load_val = EXP_W'(MULT_CYCLES);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        err_vld   = 1'b0;
        err_val   = ERR_NONE;
        if (!Req) begin
            case (state)
                IDLE: begin
                    if (track_start) begin
                        state_nxt = ARMED;
                        cnt_load  = 1'b1;
                    end
                end
                ARMED: begin
                    if (busy) begin
                        state_nxt = RUN;
                        cnt_dec   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        err_vld   = 1'b1;
                        err_val   = ERR_LATE;
                    end
                end
                RUN: begin
                    if (!busy) begin
                        state_nxt = IDLE;
                        if (!exp_zero) begin
                            err_vld = 1'b1;
                            err_val = ERR_DROP;
                        end
                    end else if (exp_zero) begin
                        // Stay until the unit finally drops busy.
                        err_vld = 1'b1;
                        err_val = ERR_OVERRUN;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (start && (state != IDLE) && !err_vld) begin
                err_vld = 1'b1;
                err_val = ERR_OVERRUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            proto_err <= 1'b0;
            err_q     <= ERR_NONE;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (err_vld && !proto_err) begin
                proto_err <= 1'b1;
                err_q     <= err_val;
            end
            if (stall_D) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    mdu_lat_counter #(
        .W(EXP_W)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .hold     (Req),
        .load     (cnt_load),
        .load_val (load_val),
        .dec      (cnt_dec),
        .zero     (exp_zero)
    );

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: stall timing, Req freeze, protocol faults, reset.
module tb_mdu_issue_ctrl;
    import mdu_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic [3:0]  MDUtype_D;
    logic [3:0]  MDUtype_E;
    logic        start;
    logic        busy;
    logic        stall_D;
    logic        proto_err;
    logic [1:0]  err_code;
    logic [31:0] stall_cnt;
    logic        shadow_busy;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Req         (Req),
        .MDUtype_D   (MDUtype_D),
        .MDUtype_E   (MDUtype_E),
        .start       (start),
        .busy        (busy),
        .stall_D     (stall_D),
        .proto_err   (proto_err),
        .err_code    (err_code),
        .stall_cnt   (stall_cnt),
        .shadow_busy (shadow_busy)
    );

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic rs, input logic [3:0] d, input logic [3:0] e,
                         input logic st, input logic bz, input logic rq);
        @(negedge clk);
        reset = rs; MDUtype_D = d; MDUtype_E = e; start = st; busy = bz; Req = rq;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 0;
        checks++; if (stall_D !== 1'b0) begin errors++; $display("FAIL reset_stall_D got %0b want 0", stall_D); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %0b want 0", proto_err); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0d want 0", err_code); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        checks++; if (shadow_busy !== 1'b0) begin errors++; $display("FAIL reset_shadow got %0b want 0", shadow_busy); end
    endtask

    // mult at i=0, busy i=1..5, mfhi waiting in D.
    task automatic test_mult_stall();
        logic es, eh;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, MDU_MFHI, (i == 0) ? MDU_MULT : MDU_NONE, i == 0, (i >= 1) && (i <= 5), 1'b0);
            es = (i <= 5);
            eh = (i >= 2) && (i <= 5);
            checks++; if (stall_D !== es) begin errors++; $display("FAIL mult_stall_D[%0d] got %0b want %0b", i, stall_D, es); end
            checks++; if (shadow_busy !== eh) begin errors++; $display("FAIL mult_shadow[%0d] got %0b want %0b", i, shadow_busy, eh); end
        end
        exp_cnt += 6;
        checks++; if (stall_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL mult_stall_cnt got %0d want %0d", stall_cnt, exp_cnt); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mult_proto_err got %0b want 0", proto_err); end
    endtask

    // div at i=0, Req high at i=3,4, busy stretched to i=1..12.
    task automatic test_div_req();
        logic es, eh;
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, MDU_MFLO, (i == 0) ? MDU_DIV : MDU_NONE, i == 0, (i >= 1) && (i <= 12),
                  (i == 3) || (i == 4));
            es = (i <= 12);
            eh = (i >= 2) && (i <= 12);
            checks++; if (stall_D !== es) begin errors++; $display("FAIL div_stall_D[%0d] got %0b want %0b", i, stall_D, es); end
            checks++; if (shadow_busy !== eh) begin errors++; $display("FAIL div_shadow[%0d] got %0b want %0b", i, shadow_busy, eh); end
        end
        exp_cnt += 13;
        checks++; if (stall_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL div_stall_cnt got %0d want %0d", stall_cnt, exp_cnt); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL div_proto_err got %0b want 0", proto_err); end
    endtask

    // Non-MDU instructions in D (0 and the unused code 9) never stall.
    task automatic test_no_use();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, (i % 2 == 1) ? 4'd9 : 4'd0, (i == 0) ? MDU_MULTU : MDU_NONE, i == 0,
                  (i >= 1) && (i <= 5), 1'b0);
            checks++; if (stall_D !== 1'b0) begin errors++; $display("FAIL nouse_stall_D[%0d] got %0b want 0", i, stall_D); end
        end
        checks++; if (stall_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL nouse_stall_cnt got %0d want %0d", stall_cnt, exp_cnt); end
    endtask

    // divu whose busy drops after 3 cycles, then a mult that never raises busy.
    task automatic test_drop_then_late();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, MDU_NONE, (i == 0) ? MDU_DIVU : MDU_NONE, i == 0, (i >= 1) && (i <= 3), 1'b0);
        end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL drop_proto_err got %0b want 1", proto_err); end
        checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL drop_err_code got %0d want 2", err_code); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, MDU_NONE, (i == 0) ? MDU_MULT : MDU_NONE, i == 0, 1'b0, 1'b0);
        end
        checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL late_keeps_code got %0d want 2", err_code); end
        for (int i = 0; i < 3; i++) drive(1'b0, MDU_NONE, MDU_NONE, 1'b0, 1'b0, 1'b0);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL drop_sticky got %0b want 1", proto_err); end
        checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL drop_code_held got %0d want 2", err_code); end
        checks++; if (stall_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL drop_stall_cnt got %0d want %0d", stall_cnt, exp_cnt); end
    endtask

    // multu with busy held 7 cycles, then a clean mult proves the FSM is back in IDLE.
    task automatic test_overrun();
        logic es, eh;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, MDU_NONE, (i == 0) ? MDU_MULTU : MDU_NONE, i == 0, (i >= 1) && (i <= 7), 1'b0);
            eh = (i >= 2) && (i <= 5);
            checks++; if (shadow_busy !== eh) begin errors++; $display("FAIL ovr_shadow[%0d] got %0b want %0b", i, shadow_busy, eh); end
        end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL ovr_proto_err got %0b want 1", proto_err); end
        checks++; if (err_code !== 2'd3) begin errors++; $display("FAIL ovr_err_code got %0d want 3", err_code); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, MDU_MTHI, (i == 0) ? MDU_MULT : MDU_NONE, i == 0, (i >= 1) && (i <= 5), 1'b0);
            es = (i <= 5);
            eh = (i >= 2) && (i <= 5);
            checks++; if (stall_D !== es) begin errors++; $display("FAIL ovr_next_stall[%0d] got %0b want %0b", i, stall_D, es); end
            checks++; if (shadow_busy !== eh) begin errors++; $display("FAIL ovr_next_shadow[%0d] got %0b want %0b", i, shadow_busy, eh); end
        end
        exp_cnt += 6;
        checks++; if (stall_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL ovr_stall_cnt got %0d want %0d", stall_cnt, exp_cnt); end
    endtask

    // Reset lands while a div is in RUN with busy still high.
    task automatic test_reset_mid_op();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, MDU_MFHI, (i == 0) ? MDU_DIV : MDU_NONE, i == 0, i >= 1, 1'b0);
        end
        drive(1'b1, MDU_MFHI, MDU_NONE, 1'b0, 1'b1, 1'b0);
        drive(1'b0, MDU_NONE, MDU_NONE, 1'b0, 1'b0, 1'b0);
        checks++; if (shadow_busy !== 1'b0) begin errors++; $display("FAIL rmid_shadow got %0b want 0", shadow_busy); end
        checks++; if (stall_D !== 1'b0) begin errors++; $display("FAIL rmid_stall_D got %0b want 0", stall_D); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rmid_proto_err got %0b want 0", proto_err); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL rmid_err_code got %0d want 0", err_code); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rmid_stall_cnt got %0d want 0", stall_cnt); end
        // A fresh mult must track normally from IDLE.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, MDU_NONE, (i == 0) ? MDU_MULT : MDU_NONE, i == 0, i >= 1, 1'b0);
        end
        checks++; if (shadow_busy !== 1'b1) begin errors++; $display("FAIL rmid_restart_shadow got %0b want 1", shadow_busy); end
    endtask

    initial begin
        reset = 1'b1; Req = 1'b0; MDUtype_D = 4'd0; MDUtype_E = 4'd0; start = 1'b0; busy = 1'b0;
        test_reset();
        test_mult_stall();
        test_div_req();
        test_no_use();
        test_drop_then_late();
        test_reset();
        test_overrun();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
